alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the combinational 64-bit datapath ALU. It registers every result with its negative/zero/overflow/carry flags and adds an iterative shift-add multiply and a logical shift-left to the existing pass/add/sub/and/or/xor operations. An architectural NZCV flag register is updated only for flag-setting instructions. It sits in the execute stage and stalls upstream through `in_ready` while a multiply is in flight.

## Interface
- `WIDTH`, default 64: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, default $clog2(WIDTH): width of the shift-amount field.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation offered.
- `in_ready` output 1: block can accept an operation this cycle.
- `A` input WIDTH: first operand.
- `B` input WIDTH: second operand; for shift, `B[SHW-1:0]` is the shift amount.
- `cntrl` input 3: operation select. 000 pass B; 001 multiply; 010 A+B; 011 A−B; 100 A&B; 101 A|B; 110 A^B; 111 A<<B[SHW-1:0].
- `set_flags` input 1: the result, when consumed, updates the NZCV register.
- `out_valid` output 1: `result` and the per-op flags are valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output WIDTH: registered result.
- `negative`, `zero`, `overflow`, `carry_out` outputs 1 each: registered per-op flags, valid with `out_valid`.
- `flag_n`, `flag_z`, `flag_c`, `flag_v` outputs 1 each: architectural NZCV register.

## Operation
- Accept on `in_valid && in_ready`; A, B, cntrl and set_flags are captured on that edge.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`. Input and output handshakes may occur in the same cycle.
- States:
  - IDLE: a non-multiply accept loads the output register directly; stays IDLE.
  - MUL: a cntrl 001 accept enters MUL with counter = 0.
  - MUL behaviour: each cycle, if multiplier bit `B_q[cnt]` is set, adds `A_q << cnt` into a 2·WIDTH accumulator; cnt increments.
  - MUL exit: when cnt == WIDTH−1, the final step loads the output register and returns to IDLE.
- Add/sub: WIDTH-bit ripple semantics. Sub is A + ~B + 1. `carry_out` is the carry from bit WIDTH−1 (sub: 1 means no borrow). `overflow` is carry into MSB XOR carry out of MSB.
- Pass, and, or, xor: `overflow = carry_out = 0`.
- Multiply (unsigned):
  - `result` is the low WIDTH bits of the product.
  - `overflow = 1` iff the upper WIDTH bits are nonzero.
  - `carry_out = 0`.
- Shift, with sh = `B[SHW-1:0]`:
  - `result = A << sh`.
  - `carry_out = A[WIDTH−sh]` if sh ≠ 0, else 0.
  - `overflow = 0`.
- All ops: `negative = result[WIDTH−1]`; `zero = (result == 0)`.
- `result` and the per-op flags hold while `out_valid && !out_ready`.
- `out_valid` clears on the output handshake unless a new result loads in the same cycle.
- NZCV register loads from the per-op flags on the output handshake iff the captured `set_flags` was 1; otherwise it holds.

## Timing
- Reset (asynchronous, `reset_n` low):
  - state = IDLE; counter and accumulator cleared.
  - `out_valid = 0`; `result = 0`; all per-op flags 0; NZCV = 0000.
  - `in_ready` = 1 in the first cycle after release.
- Non-multiply: accepted at edge k, `out_valid` high after edge k (latency 1). Back-to-back throughput is 1 op/cycle with `out_ready` held high.
- Multiply: accepted at edge k, `out_valid` high after edge k+WIDTH. `in_ready` is low from edge k until state returns to IDLE.
- Backpressure: while `out_valid && !out_ready`, `in_ready = 0`. A pending multiply completes but does not overwrite an unconsumed result: the MUL final step waits while the output slot is full.
- `reset_n` asserted mid-multiply: the operation is discarded; no output is produced; NZCV clears.
- The NZCV update is visible on `flag_*` one cycle after the output handshake edge.

## Test plan
- Reset with WIDTH=8 and `out_ready=1` -> `in_ready=1`, `out_valid=0`, result=0, NZCV=0000.
- Add then sub with WIDTH=8:
  - A=0x7F, B=0x01, add, set_flags=1 -> result 0x80, N=1 Z=0 V=1 C=0; `flag_v=1` one cycle after the handshake.
  - A=0x05, B=0x05, sub -> result 0x00, Z=1, C=1, V=0.
- Multiply with WIDTH=8:
  - A=0x10, B=0x11 -> `out_valid` exactly 8 cycles after acceptance; result 0x10, V=1; `in_ready` low throughout.
  - A=3, B=5 -> result 15, V=0.
- Shift with WIDTH=8: A=0x81, B=1 -> result 0x02, C=1. A=0x81, B=0 -> result 0x81, C=0.
- Backpressure with WIDTH=64:
  - Hold `out_ready=0` after an xor result -> result stable for 5 cycles and `in_ready=0`.
  - Release -> a queued multiply is accepted next cycle.
  - Ops issued with set_flags=0 -> NZCV unchanged.
- Mid-multiply reset: pulse `reset_n` low 3 cycles after a multiply is accepted -> no `out_valid`; outputs at reset values; a following add completes with latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: registered result and per-op flags, iterative
// shift-add multiply, logical shift-left, and an architectural NZCV register.
module alu_seq #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_MUL  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_SHL  = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH:0] SUB_ONE  = {{WIDTH{1'b0}}, 1'b1};

  state_e r_state;
  state_e w_state_nxt;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_mul_set;

  logic [WIDTH-1:0] r_result;
  logic             r_negative;
  logic             r_zero;
  logic             r_overflow;
  logic             r_carry;
  logic             r_out_valid;
  logic             r_out_set;

  logic r_flag_n;
  logic r_flag_z;
  logic r_flag_c;
  logic r_flag_v;

  logic w_slot_free;
  logic w_accept;
  logic w_accept_mul;
  logic w_accept_alu;
  logic w_mul_last;
  logic w_mul_step;
  logic w_mul_done;
  logic w_load;
  logic w_out_hs;

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_shl;
  logic [2*WIDTH-1:0] w_mul_sum;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_c_nxt;
  logic             w_v_nxt;

  // Handshake and sequencing decisions
  assign w_slot_free  = !r_out_valid || out_ready;
  assign in_ready     = (r_state == IDLE) && w_slot_free;
  assign w_accept     = in_valid && in_ready;
  assign w_accept_mul = w_accept && (cntrl == OP_MUL);
  assign w_accept_alu = w_accept && (cntrl != OP_MUL);
  assign w_mul_last   = (r_state == MUL) && (r_cnt == CNT_LAST);
  // The last multiply step stalls until the output slot can take the product.
  assign w_mul_step   = (r_state == MUL) && (!w_mul_last || w_slot_free);
  assign w_mul_done   = w_mul_last && w_slot_free;
  assign w_load       = w_accept_alu || w_mul_done;
  assign w_out_hs     = r_out_valid && out_ready;

  assign w_add     = {1'b0, A} + {1'b0, B};
  assign w_sub     = {1'b0, A} + {1'b0, ~B} + SUB_ONE;
  assign w_shl     = {1'b0, A} << B[SHW-1:0];
  assign w_mul_sum = r_acc + (r_b[r_cnt] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (cntrl)
      OP_PASS: w_alu_res = B;
      OP_ADD: begin
        w_alu_res = w_add[WIDTH-1:0];
        w_alu_c   = w_add[WIDTH];
        w_alu_v   = (w_add[WIDTH-1] ^ A[WIDTH-1] ^ B[WIDTH-1]) ^ w_add[WIDTH];
      end
      OP_SUB: begin
        w_alu_res = w_sub[WIDTH-1:0];
        w_alu_c   = w_sub[WIDTH];
        w_alu_v   = (w_sub[WIDTH-1] ^ A[WIDTH-1] ^ ~B[WIDTH-1]) ^ w_sub[WIDTH];
      end
      OP_AND:  w_alu_res = A & B;
      OP_OR:   w_alu_res = A | B;
      OP_XOR:  w_alu_res = A ^ B;
      OP_SHL: begin
        // Bit WIDTH of the widened shift is A[WIDTH-sh], and 0 when sh == 0.
        w_alu_res = w_shl[WIDTH-1:0];
        w_alu_c   = w_shl[WIDTH];
      end
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_res_nxt = w_alu_res;
    w_c_nxt   = w_alu_c;
    w_v_nxt   = w_alu_v;
    if (w_mul_done) begin
      w_res_nxt = w_mul_sum[WIDTH-1:0];
      w_c_nxt   = 1'b0;
      w_v_nxt   = |w_mul_sum[2*WIDTH-1:WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept_mul) w_state_nxt = MUL;
      MUL:     if (w_mul_done)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mul_set <= 1'b0;
    end else if (w_accept_mul) begin
      r_a       <= A;
      r_b       <= B;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mul_set <= set_flags;
    end else if (w_mul_step) begin
      r_acc <= w_mul_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result    <= '0;
      r_negative  <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_carry     <= 1'b0;
      r_out_set   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_result   <= w_res_nxt;
        r_negative <= w_res_nxt[WIDTH-1];
        r_zero     <= (w_res_nxt == '0);
        r_overflow <= w_v_nxt;
        r_carry    <= w_c_nxt;
        r_out_set  <= w_mul_done ? r_mul_set : set_flags;
      end
      r_out_valid <= w_load || (r_out_valid && !out_ready);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_out_hs && r_out_set) begin
      r_flag_n <= r_negative;
      r_flag_z <= r_zero;
      r_flag_c <= r_carry;
      r_flag_v <= r_overflow;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign negative  = r_negative;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign carry_out = r_carry;
  assign flag_n    = r_flag_n;
  assign flag_z    = r_flag_z;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;

endmodule
